ef_i2s_tx: RTL



---
 rtl/ef_i2s_tx_pkg.sv | 25 ++
 rtl/ef_i2s_tx_fifo.sv | 64 ++++++
 rtl/ef_i2s_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ef_i2s_tx_pkg.sv
// Shared constants for the I2S transmitter: slot width, channel and format encodings,
// and the helper that MSB-aligns a right-aligned sample into a 32-bit slot word.
package ef_i2s_tx_pkg;

    localparam int SLOT_BITS = 32;

    localparam logic [1:0] CH_NONE   = 2'b00;
    localparam logic [1:0] CH_RIGHT  = 2'b01;
    localparam logic [1:0] CH_LEFT   = 2'b10;
    localparam logic [1:0] CH_STEREO = 2'b11;

    typedef enum logic {
        FMT_I2S = 1'b0,
        FMT_LJ  = 1'b1
    } fmt_e;

    // Size 0 (and anything above 32) means a full 32-bit sample, i.e. no shift.
    function automatic logic [SLOT_BITS-1:0] msb_align(input logic [SLOT_BITS-1:0] data,
                                                       input logic [5:0]           size);
        logic [5:0] shamt;
        shamt = (size == 6'd0 || size >= 6'd32) ? 6'd0 : 6'd32 - size;
        return data << shamt;
    endfunction

endpackage

// File: rtl/ef_i2s_tx_fifo.sv
// Show-ahead 32-bit FIFO, depth 2**AW; head word valid whenever empty is low.
// Level/flags are registered (one cycle after push/pop); pushes while full are dropped.
module ef_i2s_tx_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [31:0]   wdata,
    input  logic          rd,
    output logic [31:0]   rdata,
    input  logic [AW:0]   threshold,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          below
);

    localparam int DEPTH = 2 ** AW;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push;
    logic          pop;
    logic [AW:0]   level_nxt;

    always_comb begin
        push      = wr && !full;
        pop       = rd && !empty;
        level_nxt = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            below <= (threshold != '0);
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            level <= level_nxt;
            full  <= (level_nxt == (AW+1)'(DEPTH));
            empty <= (level_nxt == '0);
            below <= (level_nxt < threshold);
        end
    end

endmodule

// File: rtl/ef_i2s_tx.sv
// I2S / left-justified master transmitter: SCK/WS generation, per-slot FIFO pop, MSB-first shift out.
// Underflow fill is zero, or the last popped word when EF_I2S_TX_HOLD_LAST_EN is defined.
module ef_i2s_tx #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    output logic          ws,
    output logic          sck,
    output logic          sdo,
    input  logic          fifo_wr,
    input  logic [31:0]   fifo_wdata,
    input  logic [AW:0]   fifo_level_threshold,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [AW:0]   fifo_level,
    output logic          fifo_level_below,
    output logic          underflow,
    input  logic          underflow_clr,
    input  logic          left_justified,
    input  logic [5:0]    sample_size,
    input  logic [7:0]    sck_prescaler,
    input  logic [1:0]    channels,
    input  logic          en
);
    import ef_i2s_tx_pkg::*;

    localparam int CTR_W = $clog2(SLOT_BITS);

    logic [7:0]           presc;
    logic [CTR_W-1:0]     bit_ctr;
    logic [SLOT_BITS-1:0] sr;
    logic                 lj_q;
    fmt_e                 fmt_q;

    logic                 fall;
    logic                 boundary;
    logic                 ws_next;
    logic                 slot_en;
    logic                 do_pop;
    logic                 starve;
    fmt_e                 fmt_now;
    logic                 lj_bit;
    logic [31:0]          fifo_rdata;
    logic [31:0]          fill_word;
    logic [31:0]          raw_word;
    logic [SLOT_BITS-1:0] load_word;

    ef_i2s_tx_fifo #(.AW(AW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr        (fifo_wr),
        .wdata     (fifo_wdata),
        .rd        (do_pop),
        .rdata     (fifo_rdata),
        .threshold (fifo_level_threshold),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .below     (fifo_level_below)
    );

`ifdef EF_I2S_TX_HOLD_LAST_EN
    logic [31:0] hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (do_pop) begin
            hold_q <= fifo_rdata;
        end
    end

    assign fill_word = hold_q;
`else
    assign fill_word = '0;
`endif

    // Slot configuration (channels, size, format) is only consulted at a boundary.
    always_comb begin
        fall     = en && (presc == 8'd0) && sck;
        boundary = fall && (bit_ctr == '0);
        ws_next  = ~ws;
        slot_en  = ws_next ? ((channels & CH_RIGHT) != CH_NONE)
                           : ((channels & CH_LEFT)  != CH_NONE);
        do_pop   = boundary && slot_en && !fifo_empty;
        starve   = boundary && slot_en && fifo_empty;
        raw_word = '0;
        if (slot_en) begin
            raw_word = fifo_empty ? fill_word : fifo_rdata;
        end
        load_word = msb_align(raw_word, sample_size);
        lj_bit    = boundary ? load_word[SLOT_BITS-1] : sr[SLOT_BITS-2];
        fmt_now   = boundary ? fmt_e'(left_justified) : fmt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= 8'd0;
            sck       <= 1'b0;
            ws        <= 1'b1;
            bit_ctr   <= '0;
            sr        <= '0;
            sdo       <= 1'b0;
            lj_q      <= 1'b0;
            fmt_q     <= FMT_I2S;
            underflow <= 1'b0;
        end else begin
            if (en) begin
                if (presc == 8'd0) begin
                    presc <= sck_prescaler;
                    sck   <= ~sck;
                end else begin
                    presc <= presc - 8'd1;
                end
            end
            // I2S takes the left-justified stream one SCK period late via lj_q.
            if (fall) begin
                bit_ctr <= bit_ctr + 1'b1;
                lj_q    <= lj_bit;
                sdo     <= (fmt_now == FMT_LJ) ? lj_bit : lj_q;
                if (boundary) begin
                    ws    <= ws_next;
                    sr    <= load_word;
                    fmt_q <= fmt_e'(left_justified);
                end else begin
                    sr <= sr << 1;
                end
            end
            if (starve) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
